bcd_digit_adder: RTL and testbench

Registered N-digit packed-BCD adder built from three sub-functions per digit: a 4-bit ripple-carry binary adder, a decimal-carry detector, and a +6 correction stage. Digits are chained least-significant first. Results are captured in an output register one clock after an enabled request. The block serves as the decimal arithmetic primitive for datapaths that hold values in packed BCD.

---
 rtl/bcd_digit_adder.sv | 73 +++++++
 tb/tb_bcd_digit_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_adder.sv
// Registered N-digit packed-BCD adder.
// Per digit: 4-bit ripple add, decimal-carry detect, +6 correction.
module bcd_digit_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  CIN,
    input  logic [4*DIGITS-1:0]   X,
    input  logic [4*DIGITS-1:0]   Y,
    output logic [4*DIGITS-1:0]   S,
    output logic                  CARRY,
    output logic                  VALID,
    output logic                  ERR
);

    logic [4*DIGITS-1:0] sum_d;
    logic [2*DIGITS-1:0] bad;
    logic                carry_d;
    logic [3:0]          xd;
    logic [3:0]          yd;
    logic [3:0]          f;
    logic                rc;
    logic                dc;

    always_comb begin
        sum_d   = '0;
        bad     = '0;
        carry_d = CIN;
        xd      = '0;
        yd      = '0;
        f       = '0;
        rc      = 1'b0;
        dc      = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            xd = X[4*d +: 4];
            yd = Y[4*d +: 4];
            rc = carry_d;
            for (int b = 0; b < 4; b++) begin
                f[b] = xd[b] ^ yd[b] ^ rc;
                rc   = (xd[b] & yd[b]) | (rc & (xd[b] ^ yd[b]));
            end
            dc = rc | (f[3] & f[2]) | (f[3] & f[1]);
            // +6 only touches bits [3:1]; overflow of the correction is dropped
            if (dc) begin
                sum_d[4*d +: 4] = {f[3:1] + 3'd3, f[0]};
            end else begin
                sum_d[4*d +: 4] = f;
            end
            carry_d    = dc;
            bad[2*d]   = (xd > 4'd9);
            bad[2*d+1] = (yd > 4'd9);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            S     <= '0;
            CARRY <= 1'b0;
            VALID <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            VALID <= EN;
            if (EN) begin
                S     <= sum_d;
                CARRY <= carry_d;
                ERR   <= |bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_digit_adder.sv
// Bench for bcd_digit_adder: 1-digit and 4-digit instances,
// directed steps plus random requests against a decimal model.
module tb_bcd_digit_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1, cin1, en4, cin4;
    logic [3:0]  x1, y1;
    logic [15:0] x4, y4;
    logic [3:0]  s1;
    logic [15:0] s4;
    logic        c1, v1, e1, c4, v4, e4;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bcd_digit_adder #(.DIGITS(1)) u1 (
        .CLK(clk), .RST(rst), .EN(en1), .CIN(cin1),
        .X(x1), .Y(y1), .S(s1), .CARRY(c1), .VALID(v1), .ERR(e1)
    );

    bcd_digit_adder #(.DIGITS(4)) u4 (
        .CLK(clk), .RST(rst), .EN(en4), .CIN(cin4),
        .X(x4), .Y(y4), .S(s4), .CARRY(c4), .VALID(v4), .ERR(e4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: per digit, sum > 9 carries and leaves sum-10 (mod 16)
    function automatic void model(input int n, input logic [31:0] x,
                                  input logic [31:0] y, input logic cin,
                                  output logic [31:0] s, output logic c,
                                  output logic e);
        int t, xd, yd;
        s = 0;
        c = cin;
        e = 0;
        for (int d = 0; d < n; d++) begin
            xd = int'((x >> (4*d)) & 32'hF);
            yd = int'((y >> (4*d)) & 32'hF);
            t  = xd + yd + int'(c);
            if (t > 9) begin
                s = s | (32'((t - 10) & 15) << (4*d));
                c = 1'b1;
            end else begin
                s = s | (32'(t) << (4*d));
                c = 1'b0;
            end
            if (xd > 9 || yd > 9) e = 1'b1;
        end
    endfunction

    task automatic go1(input logic [3:0] x, input logic [3:0] y,
                       input logic c);
        @(negedge clk);
        en1 = 1'b1; x1 = x; y1 = y; cin1 = c;
        @(posedge clk); #1;
    endtask

    task automatic go4(input logic [15:0] x, input logic [15:0] y,
                       input logic c);
        @(negedge clk);
        en4 = 1'b1; x4 = x; y4 = y; cin4 = c;
        @(posedge clk); #1;
    endtask

    task automatic chk1(input string tag, input logic [3:0] es,
                        input logic ec, input logic ee, input logic ev);
        chk({tag, ".s"}, 32'(s1), 32'(es));
        chk({tag, ".carry"}, 32'(c1), 32'(ec));
        chk({tag, ".err"}, 32'(e1), 32'(ee));
        chk({tag, ".valid"}, 32'(v1), 32'(ev));
    endtask

    task automatic chk4(input string tag, input logic [15:0] es,
                        input logic ec, input logic ee, input logic ev);
        chk({tag, ".s"}, 32'(s4), 32'(es));
        chk({tag, ".carry"}, 32'(c4), 32'(ec));
        chk({tag, ".err"}, 32'(e4), 32'(ee));
        chk({tag, ".valid"}, 32'(v4), 32'(ev));
    endtask

    initial begin
        logic [31:0] ms;
        logic        mc, me;
        logic [15:0] hs;
        logic        hc, he;
        logic [15:0] rx, ry;
        logic        ren, rcin;

        rst = 1'b1;
        en1 = 1'b0; cin1 = 1'b0; x1 = '0; y1 = '0;
        en4 = 1'b0; cin4 = 1'b0; x4 = '0; y4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset1", 4'h0, 1'b0, 1'b0, 1'b0);
        chk4("reset4", 16'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        go1(4'd0, 4'd3, 1'b0);
        go1(4'd0, 4'd0, 1'b0); chk1("d0_0", 4'd0, 1'b0, 1'b0, 1'b1);
        go1(4'd3, 4'd5, 1'b0); chk1("d3_5", 4'd8, 1'b0, 1'b0, 1'b1);
        go1(4'd4, 4'd6, 1'b0); chk1("d4_6", 4'd0, 1'b1, 1'b0, 1'b1);
        go1(4'd9, 4'd9, 1'b0); chk1("d9_9", 4'd8, 1'b1, 1'b0, 1'b1);
        go1(4'd7, 4'd6, 1'b0); chk1("d7_6", 4'd3, 1'b1, 1'b0, 1'b1);
        go1(4'd1, 4'd8, 1'b0); chk1("d1_8", 4'd9, 1'b0, 1'b0, 1'b1);
        go1(4'd9, 4'd9, 1'b1); chk1("c9_9", 4'd9, 1'b1, 1'b0, 1'b1);
        go1(4'd0, 4'd0, 1'b1); chk1("c0_0", 4'd1, 1'b0, 1'b0, 1'b1);
        go1(4'd4, 4'd5, 1'b1); chk1("c4_5", 4'd0, 1'b1, 1'b0, 1'b1);
        go1(4'hF, 4'hF, 1'b1); chk1("nbcd", 4'd5, 1'b1, 1'b1, 1'b1);
        go1(4'd2, 4'd2, 1'b0); chk1("clr_err", 4'd4, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        en1 = 1'b0; x1 = 4'd9; y1 = 4'd9; cin1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("hold", 4'd4, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        rst = 1'b1; en1 = 1'b1; x1 = 4'd5; y1 = 4'd5; cin1 = 1'b0;
        @(posedge clk); #1;
        chk1("rst_en", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; en1 = 1'b0;
        @(posedge clk); #1;
        chk1("post_rst", 4'd0, 1'b0, 1'b0, 1'b0);
        go1(4'd2, 4'd3, 1'b0); chk1("first_after_rst", 4'd5, 1'b0, 1'b0, 1'b1);

        for (int c = 0; c < 2; c++) begin
            for (int x = 0; x < 10; x++) begin
                for (int y = 0; y < 10; y++) begin
                    go1(4'(x), 4'(y), 1'(c));
                    model(1, 32'(x), 32'(y), 1'(c), ms, mc, me);
                    chk1("exh", ms[3:0], mc, 1'b0, 1'b1);
                    chk("exh.dec", 32'(int'(s1) + 10 * int'(c1)),
                        32'(x + y + c));
                end
            end
        end
        @(negedge clk);
        en1 = 1'b0;

        go4(16'h9999, 16'h0001, 1'b0);
        chk4("ripple", 16'h0000, 1'b1, 1'b0, 1'b1);
        go4(16'h1234, 16'h5678, 1'b0);
        chk4("mix", 16'h6912, 1'b0, 1'b0, 1'b1);
        hs = 16'h6912; hc = 1'b0; he = 1'b0;

        // random requests with random EN; outputs must hold when idle
        for (int i = 0; i < 300; i++) begin
            ren  = 1'($urandom_range(0, 3) != 0);
            rcin = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rx = 16'($urandom);
                ry = 16'($urandom);
            end else begin
                for (int d = 0; d < 4; d++) begin
                    rx[4*d +: 4] = 4'($urandom_range(0, 9));
                    ry[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end
            @(negedge clk);
            en4 = ren; x4 = rx; y4 = ry; cin4 = rcin;
            @(posedge clk); #1;
            if (ren) begin
                model(4, 32'(rx), 32'(ry), rcin, ms, mc, me);
                hs = ms[15:0]; hc = mc; he = me;
            end
            chk4("rnd", hs, hc, he, ren);
        end

        @(negedge clk);
        en4 = 1'b0;
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
